// File: rtl/instr_pkg.sv
// Shared constants and types for the instruction dispatch path.
// Field widths and unit indices used by the queue consumer.
package instr_pkg;

  localparam int DMA_BITS   = 78;
  localparam int CACHE_BITS = 17;

  typedef logic [DMA_BITS-1:0]   dma_instr_t;
  typedef logic [CACHE_BITS-1:0] cache_instr_t;

  localparam int UNIT_DMA   = 2;
  localparam int UNIT_ARITH = 1;
  localparam int UNIT_CACHE = 0;
  localparam int NUM_UNITS  = 3;

endpackage

// File: rtl/issue_slot.sv
// One issue lane: holds a registered field and its pending bit.
// Loads on pop, drops pending once the unit accepts.
module issue_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pop,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         done
);

  logic pend;

  // Load on pop (null field stays idle), clear on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
      dout <= '0;
    end else if (pop) begin
      pend <= |din;
      dout <= din;
    end else if (pend && ready) begin
      pend <= 1'b0;
    end
  end

  assign valid = pend;
  assign done  = !pend || ready;

endmodule

// File: rtl/instr_dispatch.sv
// Instruction queue consumer: pops a bundle once the last one
// fully issued and fans its fields out to three units.
module instr_dispatch #(
  parameter int DMA_BITS   = instr_pkg::DMA_BITS,
  parameter int CACHE_BITS = instr_pkg::CACHE_BITS,
  parameter int CNT_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DMA_BITS-1:0]   dma_instr,
  input  logic                  arithmetic_instr,
  input  logic [CACHE_BITS-1:0] cache_instr,
  output logic                  pop,
  output logic                  dma_valid,
  input  logic                  dma_ready,
  output logic [DMA_BITS-1:0]   dma_out,
  output logic                  arith_valid,
  input  logic                  arith_ready,
  output logic                  arith_out,
  output logic                  cache_valid,
  input  logic                  cache_ready,
  output logic [CACHE_BITS-1:0] cache_out,
  output logic                  busy,
  output logic [CNT_BITS-1:0]   pop_cnt
);

  localparam int NU = instr_pkg::NUM_UNITS;

  logic [NU-1:0] pend;
  logic [NU-1:0] done;

  issue_slot #(.W(DMA_BITS)) u_dma (
    .clk   (clk),
    .reset (reset),
    .pop   (pop),
    .din   (dma_instr),
    .ready (dma_ready),
    .valid (pend[instr_pkg::UNIT_DMA]),
    .dout  (dma_out),
    .done  (done[instr_pkg::UNIT_DMA])
  );

  issue_slot #(.W(1)) u_arith (
    .clk   (clk),
    .reset (reset),
    .pop   (pop),
    .din   (arithmetic_instr),
    .ready (arith_ready),
    .valid (pend[instr_pkg::UNIT_ARITH]),
    .dout  (arith_out),
    .done  (done[instr_pkg::UNIT_ARITH])
  );

  issue_slot #(.W(CACHE_BITS)) u_cache (
    .clk   (clk),
    .reset (reset),
    .pop   (pop),
    .din   (cache_instr),
    .ready (cache_ready),
    .valid (pend[instr_pkg::UNIT_CACHE]),
    .dout  (cache_out),
    .done  (done[instr_pkg::UNIT_CACHE])
  );

  assign dma_valid   = pend[instr_pkg::UNIT_DMA];
  assign arith_valid = pend[instr_pkg::UNIT_ARITH];
  assign cache_valid = pend[instr_pkg::UNIT_CACHE];
  assign busy        = |pend;

  // Last acceptance and next pop share a cycle.
  assign pop = !empty && (&done);

  // Count pops, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_cnt <= '0;
    end else if (pop) begin
      pop_cnt <= pop_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: doc/instr_dispatch.md
# instr_dispatch

Consumer end of the instruction queue: pops one instruction bundle (DMA, arithmetic, cache fields) from the queue head whenever the queue is non-empty and the previous bundle has fully issued. It registers the bundle and presents each non-null field to its execution unit over an independent valid/ready handshake. It sits between the instruction queue (first-word fall-through: head fields valid whenever `empty` is low) and the DMA, arithmetic and cache units.

## Interface
Parameters:
- `DMA_BITS`, 78, width of DMA instruction field
- `CACHE_BITS`, 17, width of cache instruction field
- `CNT_BITS`, 8, width of the popped-instruction counter

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; one clock, reset asynchronous active-high
- `empty`  in  1  queue has no head entry
- `dma_instr`  in  DMA_BITS  queue head DMA field
- `arithmetic_instr`  in  1  queue head arithmetic field
- `cache_instr`  in  CACHE_BITS  queue head cache field
- `pop`  out  1  combinational; consume queue head this cycle
- `dma_valid` / `dma_ready`  out / in  1  DMA handshake
- `dma_out`  out  DMA_BITS  registered DMA field
- `arith_valid` / `arith_ready`  out / in  1  arithmetic handshake
- `arith_out`  out  1  registered arithmetic field
- `cache_valid` / `cache_ready`  out / in  1  cache handshake
- `cache_out`  out  CACHE_BITS  registered cache field
- `busy`  out  1  a bundle is outstanding
- `pop_cnt`  out  CNT_BITS  number of pops, wraps modulo 2^CNT_BITS

## Operation
- State: `pend[2:0]` = {dma, arith, cache} outstanding bits; `busy` = |pend.
- Null fields: DMA null when `dma_instr == 0`, arith null when `arithmetic_instr == 0`, cache null when `cache_instr == 0`. Null fields never raise valid.
- `x_valid = pend[x]`; handshake fires when `x_valid && x_ready`; fired bit clears at the edge.
- `done` = every set pend bit fires this cycle (true when pend == 0).
- `pop = !empty && done`.
- On pop: load `dma_out`/`arith_out`/`cache_out` from queue head; `pend` = non-null mask of the head; `pop_cnt` += 1.
- Without pop: fired bits clear; data registers hold.
- All-null bundle: popped, counted, pend stays 0. Next pop possible the following cycle.
- Readies are never combinationally routed to valids. Valid stays high until accepted, and data is stable while valid.
- Units accept independently and in any order. The next bundle waits for all three.
- `empty` rising while busy: no effect until done.

## Timing
- Reset values: pend = 0, all valids 0, `busy` 0, `pop_cnt` 0, data outputs 0. `pop` is 0 while `empty`.
- Reset mid-operation: outstanding bundle discarded, no issue. The popped entry is not re-requested.
- Latency: pop at cycle N, so valids are high in N+1.
- Peak throughput: one bundle per cycle when all non-null units are ready in the cycle after the pop, since the last acceptance and the next pop share a cycle.
- `pop_cnt` wraps from 2^CNT_BITS−1 to 0.

## Structure
- Shared package `instr_pkg`:
  - `DMA_BITS`, `CACHE_BITS` constants
  - `dma_instr_t` and `cache_instr_t` typedefs
  - unit index constants (DMA = 2, ARITH = 1, CACHE = 0)
- One sub-module: `issue_slot`, instantiated three times, parameterized by width. Holds a data register and pend bit, loads on pop, clears on handshake, and outputs valid and its done term.
- Top level holds `pop` logic and the counter.

## Test plan
- Reset, then queue empty for 5 cycles: `pop` = 0, valids 0, `pop_cnt` = 0.
- Head {dma=78'h1, arith=1, cache=17'h5} with all readies high:
  - pop at N; all three valids high at N+1 with `dma_out` = 1, `cache_out` = 5.
  - next head popped at N+1; `pop_cnt` = 2 after N+1.
- Same bundle with `cache_ready` held low 3 cycles:
  - dma/arith accept at N+1; `cache_valid` stays high through N+4.
  - no pop until the cycle cache fires.
- Head all-zero followed by {0, 1, 0}:
  - first popped with no valids, `pop_cnt` = 1.
  - second popped next cycle, only `arith_valid` rises.
- 256 all-null pops with CNT_BITS = 8: `pop_cnt` returns to 0.
- Assert `reset` asynchronously while `dma_valid` is high and `dma_ready` low:
  - all valids and `busy` drop immediately.
  - first pop after release reloads from the current head.
